// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, NOP word,
// reset vector, output-slot payload and PC helpers.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // Contents of the slot presented to IF/ID.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc4;
  } slot_t;

  localparam slot_t EMPTY_SLOT = '{valid: 1'b0, ins: NOP_WORD, pc4: '0};

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  // Wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] a);
    return a + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bus between fetch_unit and imem.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Fetch PC register: async reset to RESET_PC, word-aligned load beats increment.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = word_align(load_pc);
    end else if (inc) begin
      pc_d = next_pc(pc_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and
// presents either a fetched instruction or a NOP bubble to IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  fetch_unit_if.master      imem,
  output logic [XLEN-1:0]   ins_out,
  output logic [XLEN-1:0]   PCPlus4_out,
  output logic              valid_out
);

  fetch_state_e    state_q, state_d;
  slot_t           slot_q, slot_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [XLEN-1:0] fetch_pc;
  logic            req;
  logic            fire;
  logic            resp;

  assign fire = req && imem.imem_gnt;
  assign resp = imem.imem_rvalid;

  fetch_unit_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect),
    .load_pc (redirect_pc),
    .inc     (fire),
    .pc      (fetch_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect turns any wrong-path request (just granted or in flight) into a DROP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (fire) begin
          state_d = redirect ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp) begin
          state_d = S_REQ;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (resp) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Only ask for a new word when the slot will be free at the next edge.
  always_comb begin
    req = 1'b0;
    if (!rst && (state_q == S_REQ)) begin
      req = !slot_q.valid || !stall;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc;

  always_comb begin
    pend_pc_d = pend_pc_q;
    if (fire) begin
      pend_pc_d = fetch_pc;
    end
  end

  // Consume, then load, then flush: later assignments take priority.
  always_comb begin
    slot_d = slot_q;
    if (slot_q.valid && !stall) begin
      slot_d = EMPTY_SLOT;
    end
    if ((state_q == S_WAIT) && resp) begin
      slot_d = '{valid: 1'b1, ins: imem.imem_rdata, pc4: next_pc(pend_pc_q)};
    end
    if (redirect) begin
      slot_d = EMPTY_SLOT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q    <= EMPTY_SLOT;
      pend_pc_q <= RESET_PC;
    end else begin
      slot_q    <= slot_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign ins_out     = slot_q.ins;
  assign PCPlus4_out = slot_q.pc4;
  assign valid_out   = slot_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// redirect/wrap/reset sequences and a randomized run against a queue-based model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ins_out;
  logic [31:0] pc4_out;
  logic        valid_out;

  fetch_unit_if mem_if ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (mem_if),
    .ins_out     (ins_out),
    .PCPlus4_out (pc4_out),
    .valid_out   (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Outstanding memory request as seen by the bench memory.
  typedef struct {
    logic [31:0] addr;
    int          wait_cyc;
    logic        killed;
  } mreq_t;

  mreq_t       q[$];
  logic [31:0] exp_pc;
  logic        m_valid;
  logic [31:0] m_ins;
  logic [31:0] m_pc4;
  logic        last_req;
  logic [31:0] last_addr;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        gnt;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc4;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2008_0005;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_pc  = 32'h0000_0000;
    m_valid = 1'b0;
    m_ins   = 32'h0;
    m_pc4   = 32'h0;
  endtask

  // One clock cycle, entered and left at a negedge; memory responds from the model queue.
  task automatic drive_cycle(input logic st, input logic rd, input logic [31:0] rpc,
                             input logic gnt_en, input int lat);
    logic  rv;
    logic  exp_req;
    logic  fire;
    logic  got;
    mreq_t e;
    mreq_t n;
    got         = 1'b0;
    e           = '{32'h0, 0, 1'b0};
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    rv = (q.size() != 0) && (q[0].wait_cyc == 0);
    mem_if.imem_rvalid = rv;
    mem_if.imem_rdata  = rv ? mem_word(q[0].addr) : $urandom();
    #1;
    exp_req   = (q.size() == 0) && (!m_valid || !st);
    last_req  = mem_if.imem_req;
    last_addr = mem_if.imem_addr;
    check("imem_req", 32'(mem_if.imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", mem_if.imem_addr, exp_pc);
    mem_if.imem_gnt = gnt_en && mem_if.imem_req;
    fire = gnt_en && exp_req;
    @(posedge clk);
    if (rv) begin
      e   = q.pop_front();
      got = !e.killed && !rd;
    end
    foreach (q[i]) if (q[i].wait_cyc > 0) q[i].wait_cyc--;
    if (fire) begin
      n.addr     = exp_pc;
      n.wait_cyc = lat - 1;
      n.killed   = 1'b0;
      q.push_back(n);
    end
    if (rd) begin
      foreach (q[i]) q[i].killed = 1'b1;
      exp_pc = {rpc[31:2], 2'b00};
    end else if (fire) begin
      exp_pc = exp_pc + 32'd4;
    end
    if (rd) begin
      m_valid = 1'b0; m_ins = 32'h0; m_pc4 = 32'h0;
    end else if (got) begin
      m_valid = 1'b1; m_ins = mem_word(e.addr); m_pc4 = e.addr + 32'd4;
    end else if (m_valid && !st) begin
      m_valid = 1'b0; m_ins = 32'h0; m_pc4 = 32'h0;
    end
    @(negedge clk);
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("ins_out", ins_out, m_ins);
    check("PCPlus4_out", pc4_out, m_pc4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_if.imem_gnt = 1'b0; mem_if.imem_rvalid = 1'b0; mem_if.imem_rdata = 32'h0;
    last_req = 1'b0; last_addr = 32'h0;
    model_reset();

    vecs[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h2008_0005};
    vecs[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h2008_0005};
    vecs[3] = '{1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h2008_0005};
    vecs[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h2008_0005};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b1, 32'h8, mem_word(32'h4)};
    vecs[7] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b1, 32'hC, mem_word(32'h8)};

    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(mem_if.imem_req), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_ins", ins_out, 32'h0);
    check("rst_pc4", pc4_out, 32'h0);
    rst = 1'b0;

    // Free run, then a 3-cycle stall on a valid slot, then resume.
    for (int i = 0; i < 9; i++) begin
      drive_cycle(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].gnt, vecs[i].lat);
      check("vec_req", 32'(last_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) check("vec_addr", last_addr, vecs[i].e_addr);
      check("vec_valid", 32'(valid_out), 32'(vecs[i].e_valid));
      check("vec_pc4", pc4_out, vecs[i].e_pc4);
      check("vec_ins", ins_out, vecs[i].e_ins);
    end

    // Redirect while waiting; stale response arrives two cycles later.
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 3);
    drive_cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("wait_redir_valid_c", 32'(valid_out), 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("wait_redir_drop", 32'(valid_out), 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("wait_redir_addr", last_addr, 32'h0000_0100);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("wait_redir_pc4", pc4_out, 32'h0000_0104);

    // Redirect in the same cycle as the grant.
    drive_cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1);
    check("gnt_redir_flush", 32'(valid_out), 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("gnt_redir_drop", 32'(valid_out), 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("gnt_redir_addr", last_addr, 32'h0000_0200);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("gnt_redir_pc4", pc4_out, 32'h0000_0204);

    // Redirect together with stall on a valid slot, landing on the wrap address.
    drive_cycle(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1);
    check("stall_redir_valid", 32'(valid_out), 32'h0);
    check("stall_redir_ins", ins_out, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("wrap_req_addr", last_addr, 32'hFFFF_FFFC);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("wrap_valid", 32'(valid_out), 32'h1);
    check("wrap_pc4", pc4_out, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("wrap_next_addr", last_addr, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      drive_cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8, rpc,
                  $urandom_range(0, 99) < 70, int'($urandom_range(1, 3)));
    end

    // Reset with a valid, stalled slot: outputs clear immediately.
    for (int i = 0; i < 12 && !m_valid; i++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("fill_before_reset", 32'(valid_out), 32'h1);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid_out), 32'h0);
    check("async_rst_ins", ins_out, 32'h0);
    check("async_rst_pc4", pc4_out, 32'h0);
    check("async_rst_req", 32'(mem_if.imem_req), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset during WAIT; a late response afterwards must be ignored.
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 3);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1);
    rst = 1'b1;
    mem_if.imem_gnt = 1'b0;
    #1;
    check("wait_rst_req", 32'(mem_if.imem_req), 32'h0);
    check("wait_rst_valid", 32'(valid_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    stall = 1'b0; redirect = 1'b0;
    mem_if.imem_rvalid = 1'b1;
    mem_if.imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("late_rv_req", 32'(mem_if.imem_req), 32'h1);
    check("late_rv_addr", mem_if.imem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("late_rv_valid", 32'(valid_out), 32'h0);
    check("late_rv_ins", ins_out, 32'h0);
    mem_if.imem_rvalid = 1'b0;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("post_rst_pc4", pc4_out, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core; sits directly upstream of the IF/ID pipeline register and drives its `ins_in`/`PCPlus4_in`. Owns the PC, issues one instruction-memory request at a time over a grant/response handshake, and accepts stalls from the hazard unit and redirects from branch/jump resolution. Whenever no valid instruction is available it presents a NOP, so IF/ID captures a bubble.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit: IF/ID holds this cycle; outputs must stay stable.
- `redirect`  in  1  taken branch/jump this cycle; wrong-path work is discarded.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  word-aligned request address, held while `imem_req`=1.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid, at least one cycle after grant.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `ins_out`  out  32  instruction to IF/ID; 32'h0 (NOP) when `valid_out`=0.
- `PCPlus4_out`  out  32  instruction address + 4; 32'h0 when `valid_out`=0.
- `valid_out`  out  1  output slot holds a real instruction.

## Operation
- Internal state: `fetch_pc`; `pend_pc` (address of in-flight request); output slot (`ins_out`, `PCPlus4_out`, `valid_out`); FSM {REQ, WAIT, DROP}.
- At most one request is outstanding.
- REQ: `imem_req` = !rst && (!valid_out || !stall); `imem_addr` = `fetch_pc`. When `imem_req` && `imem_gnt`: `pend_pc` <= `fetch_pc`, `fetch_pc` <= `fetch_pc` + 4 (mod 2^32), go to WAIT.
- WAIT: on `imem_rvalid`, load the slot: `ins_out` <= `imem_rdata`, `PCPlus4_out` <= `pend_pc` + 4, `valid_out` <= 1; go to REQ. The slot is always empty at this point.
- DROP: on `imem_rvalid`, discard the data and go to REQ.
- Slot consume: at any edge with `valid_out`=1 and `stall`=0, the slot clears to NOP/0/0 unless it is loaded on the same edge.
- Redirect has priority over stall and over everything else:
  - slot is flushed to NOP/0/0;
  - `fetch_pc` <= {`redirect_pc`[31:2], 2'b00};
  - next state: REQ without grant -> REQ; REQ with grant this cycle -> DROP (the granted request is wrong-path); WAIT without rvalid -> DROP; WAIT with rvalid -> REQ (data discarded); DROP without rvalid -> DROP; DROP with rvalid -> REQ.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No exception is raised.

## Timing
- Reset (asynchronous, takes effect immediately): `fetch_pc`=RESET_PC, state REQ, `valid_out`=0, `ins_out`=0, `PCPlus4_out`=0, `imem_req`=0 while `rst`=1.
- First `imem_req` appears in the first cycle after `rst` deasserts.
- Latency: with a grant in the request cycle and rvalid one cycle later, the instruction is on `ins_out` 2 cycles after the request. Throughput is 1 instruction per 2 cycles with single-cycle memory.
- `imem_addr` must not change while `imem_req`=1 and `imem_gnt`=0, except on redirect, which moves it to the new PC.
- If reset is asserted mid-request or mid-response, any late `imem_rvalid` after reset is ignored because state is REQ. The memory must be reset alongside this block.
- Outputs are pure registers; `imem_req` is combinational from state, `valid_out`, `stall` and `rst`.

## Structure
- Shared definitions header `mips_defs.vh` holds the FSM state encodings (S_REQ, S_WAIT, S_DROP), NOP word 32'h0000_0000 and the default reset vector.
- Sub-module `pc_reg`: 32-bit PC register with async reset to RESET_PC and load/increment enables. Everything else lives in `fetch_unit`.

## Test plan
- Reset then free run with 1-cycle memory, RESET_PC=0: addresses 0,4,8 are requested; `valid_out` pulses with `PCPlus4_out`=4,8,12 and data matches memory.
- Hold `stall`=1 for 3 cycles while `valid_out`=1 with `ins_out`=32'h2008_0005: outputs stay stable, `imem_req`=0, no new grant occurs; the stream resumes on release.
- Redirect to 32'h0000_0103 while in WAIT, rvalid 2 cycles later: the stale data is dropped, the next request address is 32'h0000_0100, and `valid_out` stays 0 until the new instruction arrives.
- Redirect in the same cycle as `imem_gnt`: the FSM enters DROP, the following response is discarded, and the next instruction delivered has `PCPlus4_out` = redirect_pc + 4.
- Redirect and stall together with `valid_out`=1: the slot is flushed to NOP (`ins_out`=0, `valid_out`=0) and the redirect is honored.
- `fetch_pc`=32'hFFFF_FFFC: `PCPlus4_out`=32'h0 and the next request address is 32'h0. Assert `rst` during WAIT: outputs return to 0 immediately and a late rvalid is ignored.
